// File: rtl/pu4_input_loader.sv
// Sample packer feeding the 4-input processing unit: groups four samples, issues
// them to the PU, waits out the PU pipeline and holds the result for a handshake.
module pu4_input_loader #(
  parameter int XLEN       = 5,
  parameter int PU_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [XLEN-1:0] num1,
  output logic [XLEN-1:0] num2,
  output logic [XLEN-1:0] num3,
  output logic [XLEN-1:0] num4,
  input  logic [XLEN-1:0] pu_result,
  output logic [XLEN-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy
);

  localparam int TW = PU_LATENCY + 1;

  logic [2:0]        r_cnt;
  logic [TW-1:0]     r_trk;
  logic [XLEN-1:0]   r_res_data;
  logic              r_res_valid;
  logic [4*XLEN-1:0] w_num;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_flush_go;
  logic              w_issue;

  assign w_in_ready = (r_cnt < 3'd4) && !flush;
  assign w_accept   = in_valid && w_in_ready;
  assign w_flush_go = flush && (r_cnt != 3'd0) && (r_cnt < 3'd4);
  assign w_issue    = (r_cnt == 3'd4) && (r_trk == '0) && !r_res_valid;

  // One slot per group position: collection entry plus the registered PU operand.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [XLEN-1:0] r_buf;
      logic [XLEN-1:0] r_num;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_buf <= '0;
          r_num <= '0;
        end else begin
          if (w_accept && (r_cnt == 3'(gi))) begin
            r_buf <= in_data;
          end else if (w_flush_go && (r_cnt <= 3'(gi))) begin
            r_buf <= '0;
          end
          if (w_issue) begin
            r_num <= r_buf;
          end
        end
      end

      assign w_num[gi*XLEN +: XLEN] = r_num;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (w_issue) begin
      r_cnt <= 3'd0;
    end else if (w_flush_go) begin
      r_cnt <= 3'd4;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // A single token walks the tracker; its arrival at the MSB lines up with the PU output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trk <= '0;
    end else begin
      r_trk <= {r_trk[TW-2:0], w_issue};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else if (r_trk[TW-1]) begin
      r_res_data  <= pu_result;
      r_res_valid <= 1'b1;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign num1      = w_num[0*XLEN +: XLEN];
  assign num2      = w_num[1*XLEN +: XLEN];
  assign num3      = w_num[2*XLEN +: XLEN];
  assign num4      = w_num[3*XLEN +: XLEN];
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign busy      = (r_cnt != 3'd0) || (r_trk != '0) || r_res_valid;

endmodule
